// File: rtl/board_manager.sv
// -----------------------------------------------------------------------------
// board_manager
//   Holds the Connect-Four board (ROWS x COLS cells, 2 bits each) and applies
//   gravity-based piece drops, one per clock at most.
//
// Ports
//   clk        : system clock, all state updates on the rising edge
//   rst        : asynchronous, active-low reset; clears board and heights
//   insert_en  : drop request (level sensitive, one drop per high edge)
//   player_id  : 01 = player 1, 10 = player 2 (00/11 ignored)
//   col_sel    : target column 0..COLS-1 (7 is invalid)
//   col_full   : combinational, 1 when col_sel cannot take another piece
//   board      : board[row][col], row 0 = top, 00 empty / 01 P1 / 10 P2
// -----------------------------------------------------------------------------
module board_manager #(
  parameter int ROWS = 6,
  parameter int COLS = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       insert_en,
  input  logic [1:0] player_id,
  input  logic [2:0] col_sel,
  output logic       col_full,
  output logic [1:0] board [0:ROWS-1][0:COLS-1]
);

  localparam logic [2:0] FULL_H   = 3'(ROWS);
  localparam logic [2:0] BOT_ROW  = 3'(ROWS - 1);
  localparam logic [2:0] LAST_COL = 3'(COLS - 1);

  logic [1:0] r_board  [0:ROWS-1][0:COLS-1];
  logic [2:0] r_height [0:COLS-1];

  logic       w_col_ok;
  logic [2:0] w_height_sel;
  logic       w_col_full;
  logic       w_player_ok;
  logic       w_insert;
  logic [2:0] w_row;

  // Height lookup is guarded so an out-of-range column never indexes the
  // height array; such a column is simply reported as full.
  always_comb begin
    w_col_ok     = (col_sel <= LAST_COL);
    w_height_sel = 3'd0;
    if (w_col_ok) begin
      w_height_sel = r_height[col_sel];
    end
    w_col_full   = !w_col_ok || (w_height_sel == FULL_H);
    w_player_ok  = (player_id == 2'b01) || (player_id == 2'b10);
    w_insert     = insert_en && !w_col_full && w_player_ok;
    // Lowest empty row: the bottom row minus the pieces already stacked.
    w_row        = BOT_ROW - w_height_sel;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          r_board[r][c] <= 2'b00;
        end
      end
      for (int c = 0; c < COLS; c++) begin
        r_height[c] <= 3'd0;
      end
    end else if (w_insert) begin
      r_board[w_row][col_sel] <= player_id;
      r_height[col_sel]       <= w_height_sel + 3'd1;
    end
  end

  assign col_full = w_col_full;
  assign board    = r_board;

endmodule

// File: tb/tb_board_manager.sv
module tb_board_manager;

  logic       clk;
  logic       rst;
  logic       insert_en;
  logic [1:0] player_id;
  logic [2:0] col_sel;
  logic       col_full;
  logic [1:0] board [0:5][0:6];

  logic [1:0] exp_b [0:5][0:6];
  int checks;
  int errors;

  board_manager #(.ROWS(6), .COLS(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .insert_en (insert_en),
    .player_id (player_id),
    .col_sel   (col_sel),
    .col_full  (col_full),
    .board     (board)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_board(input string tag);
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 7; c++) begin
        checks++;
        assert (board[r][c] === exp_b[r][c]) else begin
          errors++;
          $error("FAIL %s cell[%0d][%0d] observed=%0h expected=%0h",
                 tag, r, c, board[r][c], exp_b[r][c]);
        end
      end
    end
  endtask

  task automatic clear_exp();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        exp_b[r][c] = 2'b00;
  endtask

  // Present a one-cycle drop request; returns at the falling edge after the
  // sampling edge, with col_sel still pointing at the target column.
  task automatic drop(input logic [1:0] p, input logic [2:0] c);
    @(negedge clk);
    insert_en = 1'b1;
    player_id = p;
    col_sel   = c;
    @(negedge clk);
    insert_en = 1'b0;
  endtask

  initial begin
    logic [1:0] seq [0:5];
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    insert_en = 1'b0;
    player_id = 2'b00;
    col_sel   = 3'd0;
    clear_exp();

    // Reset then idle
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_board("reset_board");
    for (int c = 0; c < 7; c++) begin
      col_sel = 3'(c);
      #1;
      chk("reset_col_full", 32'(col_full), 32'd0);
    end

    // Alternating drops into column 3
    seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01;
    seq[3] = 2'b10; seq[4] = 2'b01; seq[5] = 2'b10;
    for (int i = 0; i < 6; i++) begin
      drop(seq[i], 3'd3);
      exp_b[5 - i][3] = seq[i];
      chk_board("col3_fill");
      chk("col3_full_flag", 32'(col_full), (i == 5) ? 32'd1 : 32'd0);
    end

    // Full column rejects
    drop(2'b01, 3'd3);
    chk_board("full_reject");
    chk("full_reject_flag", 32'(col_full), 32'd1);

    // Another column still accepts
    drop(2'b10, 3'd0);
    exp_b[5][0] = 2'b10;
    chk_board("col0_drop");
    chk("col0_full_flag", 32'(col_full), 32'd0);

    // Invalid column
    drop(2'b01, 3'd7);
    chk("col7_full_flag", 32'(col_full), 32'd1);
    chk_board("col7_ignored");

    // Invalid player codes
    drop(2'b00, 3'd1);
    chk_board("player00_ignored");
    drop(2'b11, 3'd1);
    chk_board("player11_ignored");
    chk("col1_full_flag", 32'(col_full), 32'd0);

    // Level-sensitive enable: two high edges drop two pieces
    @(negedge clk);
    insert_en = 1'b1;
    player_id = 2'b01;
    col_sel   = 3'd6;
    repeat (2) @(negedge clk);
    insert_en = 1'b0;
    exp_b[5][6] = 2'b01;
    exp_b[4][6] = 2'b01;
    chk_board("hold_two_drops");

    // Asynchronous reset between edges
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    clear_exp();
    chk_board("async_reset");
    col_sel = 3'd3;
    #1;
    chk("async_reset_col3_flag", 32'(col_full), 32'd0);

    // Reset wins over a simultaneous insert request
    insert_en = 1'b1;
    player_id = 2'b10;
    col_sel   = 3'd4;
    @(posedge clk);
    @(negedge clk);
    chk_board("reset_beats_insert");
    insert_en = 1'b0;
    rst       = 1'b1;

    // Drops restart from the bottom row
    drop(2'b10, 3'd4);
    exp_b[5][4] = 2'b10;
    chk_board("post_reset_drop1");
    drop(2'b01, 3'd4);
    exp_b[4][4] = 2'b01;
    chk_board("post_reset_drop2");
    chk("post_reset_col4_flag", 32'(col_full), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
